// File: rtl/matmul_result_streamer_if.sv
// ============================================================================
//  matmul_result_streamer_if
//  Frame-capture and word-stream bus for matmul_result_streamer.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface matmul_result_streamer_if;
   // Frame capture side
   logic        in_valid;
   logic        in_ready;
   logic [31:0] r1;
   logic [31:0] r2;
   logic [31:0] r3;
   logic [31:0] r4;

   // Word stream side
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [1:0]  out_idx;
   logic        out_last;

   // Status
   logic [7:0]  frame_cnt;
   logic        ovf;

   // Environment: drives frames in and accepts words out
   modport master (
      output in_valid, r1, r2, r3, r4, out_ready,
      input  in_ready, out_valid, out_data, out_idx, out_last, frame_cnt, ovf
   );

   // Streamer
   modport slave (
      input  in_valid, r1, r2, r3, r4, out_ready,
      output in_ready, out_valid, out_data, out_idx, out_last, frame_cnt, ovf
   );
endinterface

`default_nettype wire

// File: rtl/matmul_result_streamer.sv
// ============================================================================
//  matmul_result_streamer
//  Buffers up to two 4-word matmul result frames and streams them word by word
//  over valid/ready. Optional macro MMSTREAM_SAT16_EN saturates words to
//  signed 16 bits at capture.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module matmul_result_streamer (
   input  wire logic                clk1,
   input  wire logic                rst_n,
   matmul_result_streamer_if.slave  bus
);
   localparam int DEPTH = 2;

   logic [31:0] r_buf [DEPTH][4];
   logic        r_wr_ptr;
   logic        r_rd_ptr;
   logic [1:0]  r_count;
   logic [1:0]  r_word_idx;
   logic [7:0]  r_frame_cnt;
   logic        r_ovf;

   logic        w_in_ready;
   logic        w_out_valid;
   logic        w_push;
   logic        w_pop;
   logic        w_done;
   logic [31:0] w_word [4];

`ifdef MMSTREAM_SAT16_EN
   function automatic logic [31:0] f_sat16(input logic [31:0] v);
      if ($signed(v) > 32'sd32767)
         return 32'h0000_7FFF;
      else if ($signed(v) < -32'sd32768)
         return 32'hFFFF_8000;
      else
         return v;
   endfunction

   assign w_word[0] = f_sat16(bus.r1);
   assign w_word[1] = f_sat16(bus.r2);
   assign w_word[2] = f_sat16(bus.r3);
   assign w_word[3] = f_sat16(bus.r4);
`else
   assign w_word[0] = bus.r1;
   assign w_word[1] = bus.r2;
   assign w_word[2] = bus.r3;
   assign w_word[3] = bus.r4;
`endif

   // Acceptance depends only on registered count, never on out_ready.
   assign w_in_ready  = (r_count != 2'd2);
   assign w_out_valid = (r_count != 2'd0);
   assign w_push      = bus.in_valid && w_in_ready;
   assign w_pop       = w_out_valid && bus.out_ready;
   assign w_done      = w_pop && (r_word_idx == 2'd3);

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr    <= 1'b0;
         r_rd_ptr    <= 1'b0;
         r_count     <= 2'd0;
         r_word_idx  <= 2'd0;
         r_frame_cnt <= 8'd0;
         r_ovf       <= 1'b0;
      end else begin
         if (w_push)
            r_wr_ptr <= ~r_wr_ptr;
         // word_idx wraps 3 -> 0 naturally on the frame-completing pop
         if (w_pop)
            r_word_idx <= r_word_idx + 2'd1;
         if (w_done) begin
            r_rd_ptr    <= ~r_rd_ptr;
            r_frame_cnt <= r_frame_cnt + 8'd1;
         end
         if (w_push && !w_done)
            r_count <= r_count + 2'd1;
         else if (!w_push && w_done)
            r_count <= r_count - 2'd1;
         if (bus.in_valid && !w_in_ready)
            r_ovf <= 1'b1;
      end
   end

   // Storage is not reset or cleared; only valid entries are ever read out.
   always_ff @(posedge clk1) begin
      if (w_push) begin
         for (int k = 0; k < 4; k++)
            r_buf[r_wr_ptr][k] <= w_word[k];
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.out_data  = w_out_valid ? r_buf[r_rd_ptr][r_word_idx] : 32'd0;
   assign bus.out_idx   = r_word_idx;
   assign bus.out_last  = w_out_valid && (r_word_idx == 2'd3);
   assign bus.frame_cnt = r_frame_cnt;
   assign bus.ovf       = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_matmul_result_streamer.sv
// ============================================================================
//  tb_matmul_result_streamer
//  Scoreboard bench: pushes expected words on capture, a monitor checks them.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_matmul_result_streamer;
   typedef struct {
      logic [31:0] d;
      logic [1:0]  i;
      logic        l;
   } exp_t;

   logic clk1;
   logic rst_n;
   int   n_checks;
   int   n_fail;
   exp_t q[$];

   logic        stalled;
   logic [31:0] h_data;
   logic [1:0]  h_idx;
   logic        h_last;

   matmul_result_streamer_if bus ();

   matmul_result_streamer dut (
      .clk1  (clk1),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk1 = 1'b0;
   always #5 clk1 = ~clk1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk1);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", nm, act, req);
      end
   endtask

   task automatic push_x(input logic [31:0] a, b, c, d,
                         input logic [31:0] ea, eb, ec, ed,
                         input logic acc, input string nm);
      exp_t e;
      chk({"in_ready ", nm}, {31'd0, bus.in_ready}, {31'd0, acc});
      bus.in_valid = 1'b1;
      bus.r1 = a; bus.r2 = b; bus.r3 = c; bus.r4 = d;
      tick();
      bus.in_valid = 1'b0;
      if (acc) begin
         e.d = ea; e.i = 2'd0; e.l = 1'b0; q.push_back(e);
         e.d = eb; e.i = 2'd1; e.l = 1'b0; q.push_back(e);
         e.d = ec; e.i = 2'd2; e.l = 1'b0; q.push_back(e);
         e.d = ed; e.i = 2'd3; e.l = 1'b1; q.push_back(e);
      end
   endtask

   task automatic push(input logic [31:0] a, b, c, d, input logic acc, input string nm);
      push_x(a, b, c, d, a, b, c, d, acc, nm);
   endtask

   task automatic drain(input string nm);
      int n = 0;
      while (q.size() != 0 && n < 64) begin
         tick();
         n++;
      end
      chk({"drain ", nm}, q.size(), 32'd0);
   endtask

   // Monitor: compare every accepted word and hold-stability across stalls
   always @(negedge clk1) begin
      exp_t e;
      if (!rst_n) begin
         stalled = 1'b0;
      end else begin
         if (stalled) begin
            n_checks++;
            if (!bus.out_valid || bus.out_data !== h_data || bus.out_idx !== h_idx
                || bus.out_last !== h_last) begin
               n_fail++;
               $display("FAIL stall_hold: got v=%0b d=%0h i=%0d l=%0b, required v=1 d=%0h i=%0d l=%0b",
                        bus.out_valid, bus.out_data, bus.out_idx, bus.out_last, h_data, h_idx, h_last);
            end
         end
         if (bus.out_valid && bus.out_ready) begin
            n_checks++;
            if (q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_word: got d=%0h i=%0d, required no word", bus.out_data, bus.out_idx);
            end else begin
               e = q.pop_front();
               if (bus.out_data !== e.d || bus.out_idx !== e.i || bus.out_last !== e.l) begin
                  n_fail++;
                  $display("FAIL word: got d=%0h i=%0d l=%0b, required d=%0h i=%0d l=%0b",
                           bus.out_data, bus.out_idx, bus.out_last, e.d, e.i, e.l);
               end
            end
         end
         stalled = bus.out_valid && !bus.out_ready;
         h_data  = bus.out_data;
         h_idx   = bus.out_idx;
         h_last  = bus.out_last;
      end
   end

   logic pat [4];

   initial begin
      n_checks = 0;
      n_fail   = 0;
      stalled  = 1'b0;
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

      // 1. reset with in_valid held high
      rst_n = 1'b0;
      bus.in_valid  = 1'b1;
      bus.r1 = 32'd1; bus.r2 = 32'd2; bus.r3 = 32'd3; bus.r4 = 32'd4;
      bus.out_ready = 1'b1;
      repeat (3) tick();
      chk("rst in_ready",  {31'd0, bus.in_ready},  32'd1);
      chk("rst out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst out_idx",   {30'd0, bus.out_idx},   32'd0);
      chk("rst out_last",  {31'd0, bus.out_last},  32'd0);
      chk("rst out_data",  bus.out_data,           32'd0);
      chk("rst frame_cnt", {24'd0, bus.frame_cnt}, 32'd0);
      chk("rst ovf",       {31'd0, bus.ovf},       32'd0);
      rst_n = 1'b1;
      bus.in_valid = 1'b0;
      tick();
      chk("post_rst in_ready",  {31'd0, bus.in_ready},  32'd1);
      chk("post_rst out_valid", {31'd0, bus.out_valid}, 32'd0);

      // 2. single frame, one-cycle latency
      push(32'd19, 32'd22, 32'd43, 32'd50, 1'b1, "single");
      chk("latency out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("latency out_idx",   {30'd0, bus.out_idx},   32'd0);
      drain("single");
      chk("single frame_cnt", {24'd0, bus.frame_cnt}, 32'd1);
      chk("single out_valid", {31'd0, bus.out_valid}, 32'd0);

      // 3. backpressure with negative words
      bus.out_ready = 1'b0;
      push(32'd6, -32'sd13, -32'sd1, -32'sd2, 1'b1, "negatives");
      for (int k = 0; k < 40 && q.size() != 0; k++) begin
         bus.out_ready = pat[k % 4];
         tick();
      end
      chk("bp drain", q.size(), 32'd0);
      bus.out_ready = 1'b1;
      chk("bp frame_cnt", {24'd0, bus.frame_cnt}, 32'd2);

      // 4. overflow: third frame dropped while stalled
      bus.out_ready = 1'b0;
      push(32'd100, 32'd101, 32'd102, 32'd103, 1'b1, "ovf f1");
      push(32'd200, 32'd201, 32'd202, 32'd203, 1'b1, "ovf f2");
      push(32'd300, 32'd301, 32'd302, 32'd303, 1'b0, "ovf f3");
      chk("ovf set", {31'd0, bus.ovf}, 32'd1);
      bus.out_ready = 1'b1;
      drain("ovf");
      chk("ovf frame_cnt", {24'd0, bus.frame_cnt}, 32'd4);
      chk("ovf sticky",    {31'd0, bus.ovf},       32'd1);
      chk("ovf in_ready",  {31'd0, bus.in_ready},  32'd1);

      // 5a. push coinciding with last pop at count 1
      push(32'd11, 32'd12, 32'd13, 32'd14, 1'b1, "sim f1");
      repeat (3) tick();
      push(32'd21, 32'd22, 32'd23, 32'd24, 1'b1, "sim f2");
      chk("sim no_gap valid", {31'd0, bus.out_valid}, 32'd1);
      chk("sim no_gap idx",   {30'd0, bus.out_idx},   32'd0);
      chk("sim no_gap data",  bus.out_data,           32'd21);
      drain("sim1");
      chk("sim frame_cnt", {24'd0, bus.frame_cnt}, 32'd6);

      // 5b. same push at count 2 is refused
      bus.out_ready = 1'b0;
      push(32'd31, 32'd32, 32'd33, 32'd34, 1'b1, "full g1");
      push(32'd41, 32'd42, 32'd43, 32'd44, 1'b1, "full g2");
      bus.out_ready = 1'b1;
      repeat (3) tick();
      push(32'd51, 32'd52, 32'd53, 32'd54, 1'b0, "full g3");
      chk("full in_ready after", {31'd0, bus.in_ready}, 32'd1);
      drain("full");
      chk("full frame_cnt", {24'd0, bus.frame_cnt}, 32'd8);

      // Asynchronous reset mid-frame discards everything
      bus.out_ready = 1'b0;
      push(32'd7, 32'd8, 32'd9, 32'd10, 1'b1, "mid_rst");
      chk("mid_rst pre valid", {31'd0, bus.out_valid}, 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      q.delete();
      chk("mid_rst out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("mid_rst ovf",       {31'd0, bus.ovf},       32'd0);
      chk("mid_rst frame_cnt", {24'd0, bus.frame_cnt}, 32'd0);
      tick();
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      tick();
      chk("mid_rst after valid", {31'd0, bus.out_valid}, 32'd0);

      // 6. saturation build option
`ifdef MMSTREAM_SAT16_EN
      push_x(32'd40000, -32'sd40000, 32'd32767, -32'sd32768,
             32'd32767, -32'sd32768, 32'd32767, -32'sd32768, 1'b1, "sat");
`else
      push_x(32'd40000, -32'sd40000, 32'd32767, -32'sd32768,
             32'd40000, -32'sd40000, 32'd32767, -32'sd32768, 1'b1, "sat");
`endif
      drain("sat");
      chk("sat frame_cnt", {24'd0, bus.frame_cnt}, 32'd1);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

`default_nettype wire
